// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands and start/annul in, registered result and ready out.
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider, one quotient bit per cycle, signed and unsigned.
// Result is {remainder, quotient}; held with ready_o until EX drops start_i.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_nxt;
  logic [64:0] dividend, dividend_nxt;
  logic [31:0] divisor, divisor_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        neg_q, neg_q_nxt;
  logic        neg_r, neg_r_nxt;
  logic [63:0] result_q, result_nxt;
  logic        ready_q, ready_nxt;

  logic [31:0] op1_mag, op2_mag;
  logic [32:0] diff;
  logic [31:0] quot, rem;
  logic        accept;

  assign accept  = bus.start_i && !bus.annul_i;
  assign op1_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign op2_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
  assign diff    = {1'b0, dividend[63:32]} - {1'b0, divisor};
  assign quot    = neg_q ? (~dividend[31:0] + 32'd1) : dividend[31:0];
  assign rem     = neg_r ? (~dividend[64:33] + 32'd1) : dividend[64:33];

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      dividend <= '0;
      divisor  <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      cnt      <= cnt_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_q <= result_nxt;
      ready_q  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE:    if (accept) state_nxt = (bus.opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  state_nxt = bus.annul_i ? FREE : END;
      ON: begin
        if (bus.annul_i)       state_nxt = FREE;
        else if (cnt == 6'd32) state_nxt = END;
      end
      END:     if (!bus.start_i) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_comb begin
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    cnt_nxt      = cnt;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    result_nxt   = result_q;
    ready_nxt    = ready_q;
    case (state)
      FREE: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
        if (accept && bus.opdata2_i != '0) begin
          dividend_nxt = {32'b0, op1_mag, 1'b0};
          divisor_nxt  = op2_mag;
          cnt_nxt      = '0;
          neg_q_nxt    = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          neg_r_nxt    = bus.signed_div_i && bus.opdata1_i[31];
        end
      end
      BYZERO: begin
        result_nxt = '0;
        if (!bus.annul_i) begin
          dividend_nxt = '0;
          ready_nxt    = 1'b1;
        end
      end
      ON: begin
        if (bus.annul_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end else if (cnt != 6'd32) begin
          // Restoring step: subtract only when the partial remainder covers the divisor.
          if (diff[32]) dividend_nxt = {dividend[63:0], 1'b0};
          else          dividend_nxt = {diff[31:0], dividend[31:0], 1'b1};
          cnt_nxt = cnt + 6'd1;
        end else begin
          result_nxt = {rem, quot};
          ready_nxt  = 1'b1;
        end
      end
      END: begin
        if (!bus.start_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      end
      default: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
      end
    endcase
  end

endmodule
